// File: rtl/cpu_boot_pkg.sv
// rtl/cpu_boot_pkg.sv - shared types and constants for the instruction-memory boot loader
//
// Purpose : loader FSM state encoding plus checksum and word-packing widths.
// Ports   : none (package).

package cpu_boot_pkg;

    localparam int CKSUM_W        = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        LEN_LO  = 3'd0,
        LEN_HI  = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4,
        ERROR   = 3'd5
    } boot_state_t;

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - assembles little-endian 32-bit words from a byte stream
//
// Purpose : shifts accepted bytes in; the first byte of a word lands in bits 7:0.
// Ports   : clk        - clock, rising edge
//           reset      - synchronous active-high; clears the byte counter and shift register
//           byte_en    - a byte is being consumed this cycle
//           byte_in    - the byte being consumed
//           word_valid - high in the cycle the 4th byte of a word is consumed
//           word_out   - the completed word, valid with word_valid

import cpu_boot_pkg::*;

module byte_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word_out
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    // Only the first three bytes need storage; the 4th is merged straight
    // from the input so the caller can register the word on the same edge.
    assign word_valid = byte_en && (r_cnt == 2'(BYTES_PER_WORD - 1));
    assign word_out   = {byte_in, r_shift};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (byte_en) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {byte_in, r_shift[23:8]};
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - length-prefixed, checksummed program loader for the CPU instruction memory
//
// Purpose : parses N (LE16), 4*N payload bytes and an 8-bit sum; writes words to
//           imem and releases cpu_reset only after the checksum matches.
// Ports   : clk, reset          - clock and synchronous active-high reset
//           in_valid/in_ready   - byte stream handshake, in_data is the byte
//           imem_we/addr/wdata  - registered one-cycle instruction-memory write
//           cpu_reset           - held high until DONE
//           done / error        - terminal status
//           words_loaded        - words written during the current load

import cpu_boot_pkg::*;

module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    boot_state_t        r_state;
    boot_state_t        w_next;
    logic [7:0]         r_len_lo;
    logic [15:0]        r_len;
    logic [CKSUM_W-1:0] r_sum;
    logic [ADDR_W-1:0]  r_word_idx;
    logic [ADDR_W:0]    r_words_loaded;
    logic               r_imem_we;
    logic [ADDR_W-1:0]  r_imem_addr;
    logic [31:0]        r_imem_wdata;

    logic               w_accept;
    logic               w_byte_en;
    logic               w_word_valid;
    logic [31:0]        w_word;
    logic [15:0]        w_len_full;
    logic [ADDR_W:0]    w_words_next;

    assign w_accept     = in_valid && in_ready;
    assign w_byte_en    = w_accept && (r_state == PAYLOAD);
    assign w_len_full   = {in_data, r_len_lo};
    assign w_words_next = r_words_loaded + 1'b1;

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_en    (w_byte_en),
        .byte_in    (in_data),
        .word_valid (w_word_valid),
        .word_out   (w_word)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= LEN_LO;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            LEN_LO:  if (w_accept) w_next = LEN_HI;
            LEN_HI: begin
                if (w_accept) begin
                    if ({1'b0, w_len_full} > CAPACITY) w_next = ERROR;
                    else if (w_len_full == 16'd0)      w_next = CHECK;
                    else                               w_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (w_word_valid && (17'(w_words_next) == 17'(r_len)))
                    w_next = CHECK;
            end
            CHECK: begin
                if (w_accept) w_next = (in_data == r_sum) ? DONE : ERROR;
            end
            default: w_next = r_state;
        endcase
    end

    // Moore outputs
    always_comb begin
        in_ready  = 1'b0;
        cpu_reset = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (r_state)
            LEN_LO, LEN_HI, PAYLOAD, CHECK: in_ready = 1'b1;
            DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            ERROR:   error = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Length latch, checksum, address counter and write port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_lo       <= '0;
            r_len          <= '0;
            r_sum          <= '0;
            r_word_idx     <= '0;
            r_words_loaded <= '0;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= '0;
            r_imem_wdata   <= '0;
        end else begin
            r_imem_we <= w_word_valid;
            if (w_accept && (r_state == LEN_LO)) r_len_lo <= in_data;
            if (w_accept && (r_state == LEN_HI)) r_len    <= w_len_full;
            if (w_byte_en) r_sum <= r_sum + in_data;
            if (w_word_valid) begin
                r_imem_addr    <= r_word_idx;
                r_imem_wdata   <= w_word;
                r_word_idx     <= r_word_idx + 1'b1;
                r_words_loaded <= w_words_next;
            end
        end
    end

    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed self-checking bench for imem_boot_loader

module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int total = 0;
    int bad   = 0;

    int          wr_n = 0;
    logic [7:0]  wr_addr [64];
    logic [31:0] wr_data [64];
    int          base;

    always #5 clk = ~clk;

    imem_boot_loader #(.ADDR_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // Write log, sampled away from the active edge
    always @(negedge clk) begin
        if (imem_we === 1'b1 && wr_n < 64) begin
            wr_addr[wr_n] = imem_addr;
            wr_data[wr_n] = imem_wdata;
            wr_n = wr_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset with a byte offered at the same time; reset must win.
    task automatic pulse_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h01;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        idle(2);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done",      32'(done), 32'd0);
        check("rst_error",     32'(error), 32'd0);
        check("rst_we",        32'(imem_we), 32'd0);
        check("rst_addr",      32'(imem_addr), 32'd0);
        check("rst_wdata",     imem_wdata, 32'd0);
        check("rst_words",     32'(words_loaded), 32'd0);
        reset = 1'b0;

        // N=2 back-to-back; sum of payload = 0x4C
        base = wr_n;
        send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34);
        check("t1_no_early_we", 32'(imem_we), 32'd0);
        send(8'h12);
        check("t1_we0",    32'(imem_we), 32'd1);
        check("t1_addr0",  32'(imem_addr), 32'd0);
        check("t1_data0",  imem_wdata, 32'h12345678);
        send(8'hEF);
        check("t1_we_fall", 32'(imem_we), 32'd0);
        send(8'hBE); send(8'hAD); send(8'hDE);
        check("t1_we1_in_check", 32'(imem_we), 32'd1);
        check("t1_ready_check",  32'(in_ready), 32'd1);
        check("t1_cpurst_check", 32'(cpu_reset), 32'd1);
        send(8'h4C);
        check("t1_done",   32'(done), 32'd1);
        check("t1_cpurst", 32'(cpu_reset), 32'd0);
        check("t1_words",  32'(words_loaded), 32'd2);
        check("t1_ready",  32'(in_ready), 32'd0);
        idle(2);
        check("t1_nwr",    32'(wr_n - base), 32'd2);
        check("t1_wa0",    32'(wr_addr[base]), 32'd0);
        check("t1_wd0",    wr_data[base], 32'h12345678);
        check("t1_wa1",    32'(wr_addr[base+1]), 32'd1);
        check("t1_wd1",    wr_data[base+1], 32'hDEADBEEF);

        // Same image, bad checksum
        pulse_reset();
        check("t2_rst_done", 32'(done), 32'd0);
        base = wr_n;
        send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        send(8'h4D);
        idle(1);
        check("t2_error",  32'(error), 32'd1);
        check("t2_done",   32'(done), 32'd0);
        check("t2_cpurst", 32'(cpu_reset), 32'd1);
        check("t2_ready",  32'(in_ready), 32'd0);
        check("t2_nwr",    32'(wr_n - base), 32'd2);

        // N=0 with sum 00
        pulse_reset();
        base = wr_n;
        send(8'h00); send(8'h00);
        check("t3_ready_check", 32'(in_ready), 32'd1);
        send(8'h00);
        idle(1);
        check("t3_done",  32'(done), 32'd1);
        check("t3_words", 32'(words_loaded), 32'd0);
        check("t3_nwr",   32'(wr_n - base), 32'd0);

        // N=0 with wrong sum
        pulse_reset();
        send(8'h00); send(8'h00); send(8'h01);
        check("t3b_error", 32'(error), 32'd1);
        check("t3b_done",  32'(done), 32'd0);

        // N=0x0101 exceeds 256-word capacity
        pulse_reset();
        base = wr_n;
        send(8'h01);
        check("t4_not_err_yet", 32'(error), 32'd0);
        send(8'h01);
        check("t4_error", 32'(error), 32'd1);
        check("t4_ready", 32'(in_ready), 32'd0);
        idle(6);
        check("t4_nwr",   32'(wr_n - base), 32'd0);

        // N=0x0100 is exactly capacity and is accepted
        pulse_reset();
        send(8'h00); send(8'h01);
        check("t4b_error", 32'(error), 32'd0);
        check("t4b_ready", 32'(in_ready), 32'd1);

        // N=2 with 1-on/2-off valid pattern
        pulse_reset();
        base = wr_n;
        send(8'h02); idle(2); send(8'h00); idle(2);
        send(8'h78); idle(2); send(8'h56); idle(2);
        send(8'h34); idle(2); send(8'h12); idle(2);
        send(8'hEF); idle(2); send(8'hBE); idle(2);
        send(8'hAD); idle(2); send(8'hDE); idle(2);
        check("t5_pre_done", 32'(done), 32'd0);
        send(8'h4C); idle(2);
        check("t5_done",  32'(done), 32'd1);
        check("t5_words", 32'(words_loaded), 32'd2);
        check("t5_nwr",   32'(wr_n - base), 32'd2);
        check("t5_wa0",   32'(wr_addr[base]), 32'd0);
        check("t5_wd0",   wr_data[base], 32'h12345678);
        check("t5_wa1",   32'(wr_addr[base+1]), 32'd1);
        check("t5_wd1",   wr_data[base+1], 32'hDEADBEEF);

        // Reset after 6 payload bytes, then an N=1 image
        pulse_reset();
        send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE);
        pulse_reset();
        check("t6_rst_words", 32'(words_loaded), 32'd1 - 32'd1);
        check("t6_rst_we",    32'(imem_we), 32'd0);
        check("t6_rst_ready", 32'(in_ready), 32'd1);
        base = wr_n;
        send(8'h01); send(8'h00);
        send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        send(8'hAA);
        idle(2);
        check("t6_done",  32'(done), 32'd1);
        check("t6_words", 32'(words_loaded), 32'd1);
        check("t6_nwr",   32'(wr_n - base), 32'd1);
        check("t6_wa0",   32'(wr_addr[base]), 32'd0);
        check("t6_wd0",   wr_data[base], 32'h11223344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
